// File: rtl/led_pkg.sv
// Shared definitions for the LED bank scheduler.
//   - state_t   : scheduler FSM states
//   - NUM_REQ   : number of requesters competing for the LED bank
//   - LED_W     : width of one requester's LED pattern
//   - rr_pick() : round-robin winner search starting after the last owner
package led_pkg;

    localparam int NUM_REQ = 4;
    localparam int LED_W   = 6;
    localparam int PTR_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    // Returns the first requester with req high, searching last+1, last+2, ...
    // and finally last itself (lowest priority). The loop walks offsets from
    // the far end inward so the nearest hit overwrites earlier ones. When no
    // request is high the result is 'last'; callers gate on |req separately.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   last);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] pick;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + PTR_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Tick prescaler for the LED scheduler.
// Ports:
//   clk50 : clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse every 2^TICK_BIT clk50 cycles
// The counter is TICK_BIT+1 bits wide. Its top bit is the tick itself; on the
// cycle after it sets, the top bit is dropped while the low bits keep
// counting, so the period is exactly 2^TICK_BIT with no extra dead cycle.
module led_prescaler #(
    parameter int TICK_BIT = 22
) (
    input  logic clk50,
    input  logic rst_n,
    output logic tick
);

    logic [TICK_BIT:0] cnt_reg;
    logic [TICK_BIT:0] cnt_next;

    always_comb begin
        cnt_next = {1'b0, cnt_reg[TICK_BIT-1:0]} + {{TICK_BIT{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = cnt_reg[TICK_BIT];

endmodule

// File: rtl/led_sched.sv
// Round-robin scheduler granting a shared 6-bit LED bank to one of four
// requesters, with a minimum ownership time measured in prescaler ticks.
// Ports:
//   clk50   : clock
//   rst_n   : asynchronous active-low reset
//   req     : per-requester request
//   pattern : requester i pattern on bits [6i+5:6i]
//   grant   : one-hot owner, or zero when nobody owns the bank
//   leds    : registered LED drive (owner pattern, else zero)
//   blink   : heartbeat, toggles on each tick while idle
//   tick    : prescaler pulse, once per tick period
module led_sched
    import led_pkg::*;
#(
    parameter int TICK_BIT   = 22,
    parameter int HOLD_TICKS = 4
) (
    input  logic                     clk50,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] pattern,
    output logic [NUM_REQ-1:0]       grant,
    output logic [LED_W-1:0]         leds,
    output logic                     blink,
    output logic                     tick
);

    localparam logic [7:0]         HOLD_MAX = 8'(HOLD_TICKS);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       last_reg, last_next;     // current/last owner
    logic [7:0]             hold_reg, hold_next;
    logic [NUM_REQ-1:0]     grant_reg, grant_next;
    logic [LED_W-1:0]       leds_reg, leds_next;
    logic                   blink_reg, blink_next;

    logic [LED_W-1:0]       pat_arr [NUM_REQ];
    logic [PTR_W-1:0]       winner;
    logic                   any_req;
    logic [NUM_REQ-1:0]     owner_mask;

    led_prescaler #(
        .TICK_BIT (TICK_BIT)
    ) u_prescaler (
        .clk50 (clk50),
        .rst_n (rst_n),
        .tick  (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pat
            assign pat_arr[gi] = pattern[gi*LED_W +: LED_W];
        end
    endgenerate

    assign winner     = rr_pick(req, last_reg);
    assign any_req    = |req;
    assign owner_mask = ONE_HOT0 << last_reg;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        hold_next  = hold_reg;
        grant_next = grant_reg;
        leds_next  = leds_reg;
        blink_next = blink_reg;

        case (state_reg)
            IDLE: begin
                grant_next = '0;
                leds_next  = '0;
                if (tick) begin
                    blink_next = ~blink_reg;
                end
                if (any_req) begin
                    state_next = OWN;
                    grant_next = ONE_HOT0 << winner;
                    last_next  = winner;
                    hold_next  = '0;
                end
            end

            OWN: begin
                leds_next = pat_arr[last_reg];
                if (tick && (hold_reg != HOLD_MAX)) begin
                    hold_next = hold_reg + 8'd1;
                end
                // Dropping the request releases immediately; otherwise the
                // owner is only preempted once its hold time has elapsed.
                if ((req & owner_mask) == '0) begin
                    state_next = SWITCH;
                    grant_next = '0;
                    leds_next  = '0;
                end else if ((hold_reg == HOLD_MAX) && ((req & ~owner_mask) != '0)) begin
                    state_next = SWITCH;
                    grant_next = '0;
                    leds_next  = '0;
                end
            end

            SWITCH: begin
                grant_next = '0;
                leds_next  = '0;
                if (any_req) begin
                    state_next = OWN;
                    grant_next = ONE_HOT0 << winner;
                    last_next  = winner;
                    hold_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
                leds_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= PTR_W'(NUM_REQ - 1);
            hold_reg  <= '0;
            grant_reg <= '0;
            leds_reg  <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            hold_reg  <= hold_next;
            grant_reg <= grant_next;
            leds_reg  <= leds_next;
            blink_reg <= blink_next;
        end
    end

    assign grant = grant_reg;
    assign leds  = leds_reg;
    assign blink = blink_reg;

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 Parameter TICK_BIT, default 22: prescaler bit; tick period is 2^TICK_BIT clk50 cycles.
REQ-002 Parameter HOLD_TICKS, default 4: minimum ownership time, in ticks, before preemption (range 1..255).
REQ-003 Port clk50 input 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n input 1: asynchronous, active-low reset.
REQ-005 Port req input 4: per-requester request for the LED bank.
REQ-006 Port pattern input 24: requester i pattern on bits [6i+5:6i].
REQ-007 Port grant output 4: one-hot owner indication, or all zero.
REQ-008 Port leds output 6: registered LED drive.
REQ-009 Port blink output 1: heartbeat; toggles on every tick while no owner exists.
REQ-010 Port tick output 1: one-cycle pulse, once per tick period.

Function
REQ-011 Prescaler: free-running counter of width TICK_BIT+1; tick pulses for one cycle each time bit TICK_BIT sets, and that bit is cleared on the next cycle.
REQ-012 FSM states: IDLE, OWN, SWITCH.
REQ-013 IDLE: if any req is high, the round-robin winner is granted on the next edge and the FSM goes to OWN; grant latency is 1 cycle.
REQ-014 Round-robin: search starts at the index after the last owner, wrapping 3->0; after reset the last owner is 3, so requester 0 has first priority.
REQ-015 OWN: leds <= pattern of the owner every cycle (1-cycle latency); the hold counter resets to 0 on entry and increments on each tick, saturating at HOLD_TICKS.
REQ-016 OWN, owner drops req: go to SWITCH on the next edge, whatever the hold count.
REQ-017 OWN, hold==HOLD_TICKS and another req is high: go to SWITCH.
REQ-018 OWN, hold==HOLD_TICKS and no other req is high: remain in OWN.
REQ-019 SWITCH: lasts exactly 1 cycle with grant=0 and leds=0; then grant the round-robin winner (excluding no one) and enter OWN, or go to IDLE if no req is high.
REQ-020 A tick coinciding with a state transition is counted only if the FSM is in OWN on that cycle.
REQ-021 Requests arriving in the same cycle are resolved purely by the round-robin order.
REQ-022 Pattern changes from the owner during OWN propagate to leds with 1-cycle latency; non-owner patterns are ignored.
REQ-023 IDLE and SWITCH: leds = 0; blink toggles on tick only in IDLE and holds its value otherwise.
REQ-024 grant is never multi-hot; at most one bit is high in any cycle.

Reset
REQ-025 rst_n low asynchronously forces: state=IDLE, grant=0, leds=0, blink=0, tick=0, prescaler=0, hold=0, last owner=3.
REQ-026 Reset asserted mid-ownership drops grant and leds immediately, without waiting for a clock edge.
REQ-027 After deassertion, the first grant occurs no earlier than 1 cycle after req is sampled high.

Structure
REQ-028 Shared package led_pkg holds: the state enum (IDLE/OWN/SWITCH), NUM_REQ=4, LED_W=6.
REQ-029 The prescaler is a sub-module, led_prescaler (params TICK_BIT; ports clk50, rst_n, tick); the FSM and arbiter stay in led_sched.

Verification
REQ-030 All cases use TICK_BIT=2 and HOLD_TICKS=3.
REQ-031 Reset, then req=0 for 40 cycles -> tick every 4 cycles; blink toggles at each tick; leds=0; grant=0.
REQ-032 req=0001, pattern0=6'h2A -> grant=0001 after 1 cycle; leds=6'h2A one cycle later; blink frozen.
REQ-033 req=1111 held continuously -> grants cycle 0001, 0010, 0100, 1000, 0001; each owner holds for 3 ticks; one SWITCH cycle with leds=0 between owners.
REQ-034 Owner 2 drops req after 1 tick while req3 is high -> SWITCH on the next edge, then grant=1000 without waiting for hold.
REQ-035 Single owner holds past 3 ticks with no other req -> stays in OWN indefinitely; req1 then rises -> SWITCH on the next edge, then grant=0010.
REQ-036 rst_n pulsed low mid-OWN between clock edges -> grant=0 and leds=0 immediately; after release with req=0100 -> grant=0100 after 1 cycle (pointer was reset).
